// File: rtl/alu_cmd_sequencer_pkg.sv
// ============================================================================
// alu_cmd_sequencer_pkg
// Shared types and constants for the ALU command sequencer:
//   - seq_state_t : sequencer FSM states
//   - command-word field positions (for the default operand width, plus
//     helper functions for any width N)
//   - ALU opcode encodings carried in cmd[17:16]
// ============================================================================
package alu_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        REQ      = 3'd2,
        WAIT_ACK = 3'd3,
        RELEASE  = 3'd4,
        DONE     = 3'd5
    } seq_state_t;

    // Command word layout: {cmd[1:0], op1[N-1:0], op2[N-1:0]}
    localparam int DEF_N   = 8;
    localparam int CMD_MSB = 2 * DEF_N + 1;
    localparam int OP1_MSB = 2 * DEF_N - 1;
    localparam int OP2_MSB = DEF_N - 1;

    function automatic int cmd_msb(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int op1_msb(input int n);
        return 2 * n - 1;
    endfunction

    function automatic int op2_msb(input int n);
        return n - 1;
    endfunction

    // ALU opcodes
    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_AND = 2'b10;
    localparam logic [1:0] ALU_OP_OR  = 2'b11;

endpackage

// File: rtl/alu_cmd_sequencer_seq_timeout_ctr.sv
// ============================================================================
// seq_timeout_ctr
// Loadable down-counter guarding the Req/Ack handshake.
//   i_clk    : clock, rising edge
//   i_rst    : asynchronous active-high reset
//   i_clr    : force the counter to zero (idle)
//   i_load   : reload with TIMEOUT-1 (asserted on every state entry)
//   i_en     : count this cycle (sequencer is in a handshake state)
//   o_expire : TIMEOUT enabled cycles have elapsed since the last load
// ============================================================================
module seq_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Loading TIMEOUT-1 makes the TIMEOUT-th enabled cycle the one that sees
    // zero, so the owner leaves the state exactly TIMEOUT cycles after entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expire = i_en && (r_count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer
// Walks a combinational command ROM, splits each word into {cmd, op1, op2},
// issues it to the ALU over a four-phase Req/Ack handshake, captures the
// result and counts completed commands. A timeout aborts a stuck handshake.
//
// Ports:
//   Clk, Rst        : clock (rising edge), async active-high reset
//   Start, Cin_In   : run start pulse (IDLE/DONE only), carry-in latched at Start
//   Rom_Addr/Data   : ROM address out, command word in
//   Alu_Cmd/Op1/Op2 : command fields to the ALU
//   Alu_Cin, Alu_Req: carry-in and request to the ALU
//   Alu_Ack, Alu_Out: acknowledge and result from the ALU
//   Result, Result_Valid : last captured result, one-cycle update pulse
//   cmd_cntr        : completed commands this run
//   Busy, Done, Err : running, finished, sticky timeout flag
// All outputs are registered.
// ============================================================================
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int N        = 8,
    parameter int ADDR_W   = 8,
    parameter int NUM_CMDS = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Cin_In,
    output logic [ADDR_W-1:0] Rom_Addr,
    input  logic [2*N+1:0]    Rom_Data,
    output logic [1:0]        Alu_Cmd,
    output logic [N-1:0]      Alu_Op1,
    output logic [N-1:0]      Alu_Op2,
    output logic              Alu_Cin,
    output logic              Alu_Req,
    input  logic              Alu_Ack,
    input  logic [15:0]       Alu_Out,
    output logic [15:0]       Result,
    output logic              Result_Valid,
    output logic [15:0]       cmd_cntr,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int          L_CMD_MSB  = cmd_msb(N);
    localparam int          L_OP1_MSB  = op1_msb(N);
    localparam int          L_OP2_MSB  = op2_msb(N);
    localparam logic [15:0] L_NUM_CMDS = 16'(NUM_CMDS);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [1:0]        w_cmd_nxt;
    logic [N-1:0]      w_op1_nxt;
    logic [N-1:0]      w_op2_nxt;
    logic              w_cin_nxt;
    logic              w_req_nxt;
    logic [15:0]       w_result_nxt;
    logic              w_rvalid_nxt;
    logic [15:0]       w_cntr_nxt;
    logic              w_err_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_expire;
    logic              w_to_en;
    logic              w_to_load;
    logic              w_to_clr;

    // ------------------------------------------------------------------
    // Handshake timeout: reloaded on every state change, counting only in
    // the three states that wait on the ALU.
    // ------------------------------------------------------------------
    assign w_to_en   = (r_state == REQ) || (r_state == WAIT_ACK) || (r_state == RELEASE);
    assign w_to_load = (w_state_nxt != r_state);
    assign w_to_clr  = !w_busy_nxt;

    seq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk    (Clk),
        .i_rst    (Rst),
        .i_clr    (w_to_clr),
        .i_load   (w_to_load),
        .i_en     (w_to_en),
        .o_expire (w_expire)
    );

    // Status flags follow the state being entered so they line up with it.
    assign w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
    assign w_done_nxt = (w_state_nxt == DONE);

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        w_state_nxt  = r_state;
        w_addr_nxt   = Rom_Addr;
        w_cmd_nxt    = Alu_Cmd;
        w_op1_nxt    = Alu_Op1;
        w_op2_nxt    = Alu_Op2;
        w_cin_nxt    = Alu_Cin;
        w_req_nxt    = Alu_Req;
        w_result_nxt = Result;
        w_rvalid_nxt = 1'b0;
        w_cntr_nxt   = cmd_cntr;
        w_err_nxt    = Err;

        case (r_state)
            IDLE, DONE: begin
                if (Start) begin
                    w_state_nxt = FETCH;
                    w_addr_nxt  = '0;
                    w_cntr_nxt  = '0;
                    w_err_nxt   = 1'b0;
                    w_cin_nxt   = Cin_In;
                end
            end

            FETCH: begin
                w_cmd_nxt   = Rom_Data[L_CMD_MSB -: 2];
                w_op1_nxt   = Rom_Data[L_OP1_MSB -: N];
                w_op2_nxt   = Rom_Data[L_OP2_MSB -: N];
                w_state_nxt = REQ;
            end

            REQ: begin
                // A stale Ack from the previous exchange must clear before a new Req.
                if (!Alu_Ack) begin
                    w_req_nxt   = 1'b1;
                    w_state_nxt = WAIT_ACK;
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end
            end

            WAIT_ACK: begin
                // A completed handshake wins over a coincident timeout.
                if (Alu_Ack) begin
                    w_result_nxt = Alu_Out;
                    w_rvalid_nxt = 1'b1;
                    w_cntr_nxt   = cmd_cntr + 16'd1;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = RELEASE;
                end else if (w_expire) begin
                    w_err_nxt    = 1'b1;
                    w_req_nxt    = 1'b0;
                    w_state_nxt  = DONE;
                end
            end

            RELEASE: begin
                if (!Alu_Ack) begin
                    if (cmd_cntr == L_NUM_CMDS) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_addr_nxt  = Rom_Addr + 1'b1;
                        w_state_nxt = FETCH;
                    end
                end else if (w_expire) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= IDLE;
            Rom_Addr     <= '0;
            Alu_Cmd      <= '0;
            Alu_Op1      <= '0;
            Alu_Op2      <= '0;
            Alu_Cin      <= 1'b0;
            Alu_Req      <= 1'b0;
            Result       <= '0;
            Result_Valid <= 1'b0;
            cmd_cntr     <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Err          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the statement order.
            r_state      <= w_state_nxt;
            Rom_Addr     <= w_addr_nxt;
            Alu_Cmd      <= w_cmd_nxt;
            Alu_Op1      <= w_op1_nxt;
            Alu_Op2      <= w_op2_nxt;
            Alu_Cin      <= w_cin_nxt;
            Alu_Req      <= w_req_nxt;
            Result       <= w_result_nxt;
            Result_Valid <= w_rvalid_nxt;
            cmd_cntr     <= w_cntr_nxt;
            Busy         <= w_busy_nxt;
            Done         <= w_done_nxt;
            Err          <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer: a table of run scenarios plus
// hand-written sequences for Ack stalls and mid-handshake reset. A simple
// ALU model answers requests; a monitor checks every issued command against
// the ROM and every captured result against what the ALU model drove.
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_cmd_sequencer_pkg::*;

    localparam int N        = 8;
    localparam int ADDR_W   = 8;
    localparam int NUM_CMDS = 16;
    localparam int TIMEOUT  = 64;
    localparam int W        = 2 * N + 2;
    localparam int ROM_SZ   = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              cin_in = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [W-1:0]      rom_data;
    logic [1:0]        alu_cmd;
    logic [N-1:0]      alu_op1;
    logic [N-1:0]      alu_op2;
    logic              alu_cin;
    logic              alu_req;
    logic              alu_ack;
    logic [15:0]       alu_out = 16'h0;
    logic [15:0]       result;
    logic              result_valid;
    logic [15:0]       cmd_cntr;
    logic              busy;
    logic              done;
    logic              err;

    logic [W-1:0]      rom [ROM_SZ];
    logic              ack_model = 1'b0;
    logic              ack_force = 1'b0;

    assign rom_data = rom[rom_addr];
    assign alu_ack  = ack_model | ack_force;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .N        (N),
        .ADDR_W   (ADDR_W),
        .NUM_CMDS (NUM_CMDS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .Start        (start),
        .Cin_In       (cin_in),
        .Rom_Addr     (rom_addr),
        .Rom_Data     (rom_data),
        .Alu_Cmd      (alu_cmd),
        .Alu_Op1      (alu_op1),
        .Alu_Op2      (alu_op2),
        .Alu_Cin      (alu_cin),
        .Alu_Req      (alu_req),
        .Alu_Ack      (alu_ack),
        .Alu_Out      (alu_out),
        .Result       (result),
        .Result_Valid (result_valid),
        .cmd_cntr     (cmd_cntr),
        .Busy         (busy),
        .Done         (done),
        .Err          (err)
    );

    // ---------------- scoreboard / model state ----------------
    int          tests = 0;
    int          fails = 0;
    bit          rand_mode = 1'b0;
    int          cur_delay = 0;
    int          cur_hold = 0;
    int          dly_cnt = 0;
    int          hold_cnt = 0;
    int          no_ack_idx = -1;
    int          model_idx = 0;
    int          req_no = 0;
    int          rv_count = 0;
    logic        run_cin = 1'b0;
    logic        prev_req = 1'b0;
    logic        ack_at_edge = 1'b0;
    logic [15:0] exp_q [$];

    typedef struct {
        bit rnd;        // per-command random Ack delay/hold
        int delay;      // cycles after Req before Ack rises
        int hold;       // extra cycles Ack stays high after Req falls
        bit cin;
        int no_ack;     // command index the ALU never acknowledges, -1 none
        int poke_at;    // cycle to pulse Start mid-run, -1 none
        int exp_cntr;
        bit exp_err;
        int exp_addr;
        int exp_cycles; // cycles from Start edge to Done, -1 unchecked
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_func(input logic [1:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b, input logic c);
        case (op)
            ALU_OP_ADD: return 16'(a) + 16'(b) + 16'(c);
            ALU_OP_SUB: return 16'(a) - 16'(b);
            ALU_OP_AND: return 16'(a & b);
            default:    return 16'(a | b);
        endcase
    endfunction

    // One clock: ALU model reacts just after the edge, monitor samples at the negedge.
    task automatic step();
        int          cur;
        logic [15:0] e;
        @(posedge clk);
        ack_at_edge = alu_ack;
        #2;
        start = 1'b0;
        if (!ack_model) begin
            if (alu_req && (model_idx != no_ack_idx)) begin
                if (dly_cnt >= cur_delay) begin
                    alu_out   = alu_func(alu_cmd, alu_op1, alu_op2, alu_cin);
                    ack_model = 1'b1;
                    hold_cnt  = 0;
                    exp_q.push_back(alu_out);
                end else begin
                    dly_cnt++;
                end
            end
        end else if (!alu_req) begin
            if (hold_cnt >= cur_hold) begin
                ack_model = 1'b0;
                dly_cnt   = 0;
                model_idx++;
                if (rand_mode) begin
                    cur_delay = $urandom_range(0, 5);
                    cur_hold  = $urandom_range(0, 5);
                end
            end else begin
                hold_cnt++;
            end
        end
        @(negedge clk);
        if (alu_req && !prev_req) begin
            cur = req_no;
            check("req_after_ack_low", 64'(ack_at_edge), 64'(0));
            check("rom_addr_at_req", 64'(rom_addr), 64'(cur % ROM_SZ));
            check("cin_at_req", 64'(alu_cin), 64'(run_cin));
            req_no++;
        end
        if (alu_req) begin
            cur = (req_no - 1) % ROM_SZ;
            check("operands_stable", 64'({alu_cmd, alu_op1, alu_op2}), 64'(rom[cur]));
        end
        if (result_valid) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
            rv_count++;
            check("result", 64'(result), 64'(e));
            check("cmd_cntr_at_rv", 64'(cmd_cntr), 64'(rv_count));
        end
        prev_req = alu_req;
    endtask

    task automatic start_run(input logic cin);
        run_cin   = cin;
        req_no    = 0;
        rv_count  = 0;
        model_idx = 0;
        dly_cnt   = 0;
        exp_q.delete();
        cin_in = cin;
        start  = 1'b1;
        step();
        cin_in = ~cin;
        check("busy_after_start", 64'(busy), 64'(1));
        check("err_clr_at_start", 64'(err), 64'(0));
        check("done_clr_at_start", 64'(done), 64'(0));
        check("addr_at_start", 64'(rom_addr), 64'(0));
        check("cntr_at_start", 64'(cmd_cntr), 64'(0));
    endtask

    task automatic wait_done(input int budget, input int poke_at, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            if (cycles == poke_at) begin
                start  = 1'b1;
                cin_in = ~run_cin;
            end
            step();
            cycles++;
        end
        if (!done) check("done_within_budget", 64'(done), 64'(1));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cycles;
        rand_mode  = v.rnd;
        cur_delay  = v.rnd ? int'($urandom_range(0, 5)) : v.delay;
        cur_hold   = v.rnd ? int'($urandom_range(0, 5)) : v.hold;
        no_ack_idx = v.no_ack;
        start_run(v.cin);
        wait_done(3000, v.poke_at, cycles);
        if (v.exp_cycles >= 0) check({tag, "_cycles"}, 64'(cycles), 64'(v.exp_cycles));
        check({tag, "_cmd_cntr"}, 64'(cmd_cntr), 64'(v.exp_cntr));
        check({tag, "_rv_pulses"}, 64'(rv_count), 64'(v.exp_cntr));
        check({tag, "_err"}, 64'(err), 64'(v.exp_err));
        check({tag, "_done_busy"}, 64'({done, busy}), 64'(2'b10));
        check({tag, "_req_low"}, 64'(alu_req), 64'(0));
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'(v.exp_addr));
        check({tag, "_ops_hold"}, 64'({alu_cmd, alu_op1, alu_op2}), 64'(rom[v.exp_addr]));
    endtask

    task automatic fill_rom();
        for (int a = 0; a < ROM_SZ; a++) rom[a] = W'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   cycles;
        int   cnt;

        //           rnd d  h  cin no_ack poke | cntr     err addr          cycles
        vecs[0] = '{0, 0, 0, 1, -1, -1, NUM_CMDS, 0, NUM_CMDS - 1, NUM_CMDS * 4};
        vecs[1] = '{0, 0, 5, 0, -1, -1, NUM_CMDS, 0, NUM_CMDS - 1, NUM_CMDS * 9};
        vecs[2] = '{0, 3, 2, 1, -1, 10, NUM_CMDS, 0, NUM_CMDS - 1, NUM_CMDS * 9};
        vecs[3] = '{0, 0, 0, 1,  3, -1, 3,        1, 3,            3 * 4 + 2 + TIMEOUT};
        vecs[4] = '{1, 0, 0, 0, -1, -1, NUM_CMDS, 0, NUM_CMDS - 1, -1};
        vecs[5] = '{1, 0, 0, 1, -1, 20, NUM_CMDS, 0, NUM_CMDS - 1, -1};

        fill_rom();
        repeat (3) step();
        check("reset_outputs",
              {rom_addr, alu_cmd, alu_op1, alu_op2, alu_cin, alu_req, result,
               result_valid, cmd_cntr, busy, done, err}, 64'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            fill_rom();
            if (i == 0) rom[0] = 18'b01_00000011_00000101;
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Ack held high before the run: Req must wait in REQ until it falls.
        fill_rom();
        rand_mode  = 1'b0;
        cur_delay  = 0;
        cur_hold   = 0;
        no_ack_idx = -1;
        ack_force  = 1'b1;
        start_run(1'b0);
        repeat (10) step();
        check("req_blocked_by_ack", 64'(alu_req), 64'(0));
        check("busy_while_blocked", 64'(busy), 64'(1));
        ack_force = 1'b0;
        wait_done(3000, -1, cycles);
        check("stall_total_cycles", 64'(10 + cycles), 64'(NUM_CMDS * 4 + 9));
        check("stall_cmd_cntr", 64'(cmd_cntr), 64'(NUM_CMDS));
        check("stall_err", 64'(err), 64'(0));

        // Reset while command 7 waits for Ack.
        fill_rom();
        cur_delay = 4;
        start_run(1'b1);
        cnt = 0;
        while (req_no < 8 && cnt < 500) begin
            step();
            cnt++;
        end
        check("reached_cmd7", 64'(req_no), 64'(8));
        check("req_high_before_rst", 64'(alu_req), 64'(1));
        check("cntr_before_rst", 64'(cmd_cntr), 64'(7));
        rst = 1'b1;
        #1;
        check("async_reset_outputs",
              {rom_addr, alu_cmd, alu_op1, alu_op2, alu_cin, alu_req, result,
               result_valid, cmd_cntr, busy, done, err}, 64'(0));
        ack_model = 1'b0;
        prev_req  = 1'b0;
        exp_q.delete();
        step();
        rst = 1'b0;
        step();
        run_vec(vecs[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequences the command ROM into MyALU: fetches each 18-bit command word and splits it into cmd[17:16], op1[15:8] and op2[7:0].
- Issues each command over a four-phase Req/Ack handshake, captures Alu_Out and counts completed commands.
- Replaces the free-running fetch/count logic at top level with a controlled run/stop engine that has ack-timeout protection.

Parameters:
N, 8, operand width; command word width is 2*N+2.
ADDR_W, 8, ROM address width.
NUM_CMDS, 16, commands per run, 1..2**ADDR_W.
TIMEOUT, 64, max cycles waiting for Ack rise or fall before error.

Ports:
Clk  in  1  system clock, rising edge.
Rst  in  1  asynchronous, active-high reset.
Start  in  1  one-cycle pulse; begins a run; sampled only in IDLE.
Cin_In  in  1  carry-in; latched at Start, held for the whole run.
Rom_Addr  out  ADDR_W  ROM address (ROM read is combinational).
Rom_Data  in  2*N+2  command word at Rom_Addr.
Alu_Cmd  out  2  opcode to ALU.
Alu_Op1  out  N  operand 1.
Alu_Op2  out  N  operand 2.
Alu_Cin  out  1  carry-in to ALU.
Alu_Req  out  1  request to ALU.
Alu_Ack  in  1  ALU acknowledge.
Alu_Out  in  16  ALU result.
Result  out  16  last captured result.
Result_Valid  out  1  one-cycle pulse when Result updates.
cmd_cntr  out  16  completed commands this run.
Busy  out  1  high outside IDLE/DONE.
Done  out  1  high in DONE until next Start.
Err  out  1  sticky timeout flag; cleared by Start or Rst.

Behaviour:
- Reset: state IDLE. Rom_Addr, Alu_* outputs, Result, cmd_cntr = 0. Result_Valid, Busy, Done, Err = 0. Asserting Rst mid-handshake drops Alu_Req immediately; no partial count is retained.
- All outputs are registered.
- IDLE:
  - On Start: clear cmd_cntr, Err and Done; Rom_Addr = 0; latch Cin_In; go to FETCH.
  - Start in any other state is ignored, except in DONE, where it behaves as in IDLE.
- FETCH (1 cycle): register Rom_Data fields into Alu_Cmd/Op1/Op2; go to REQ.
- REQ:
  - Requires Alu_Ack low. If Alu_Ack is still high, stay here; this cycle counts toward the timeout.
  - Once Ack is low, assert Alu_Req; go to WAIT_ACK.
- WAIT_ACK:
  - Req held high and operands stable.
  - On Alu_Ack = 1: Result <= Alu_Out; Result_Valid pulses the next cycle; cmd_cntr += 1 (wraps at 16 bits); Alu_Req <= 0; go to RELEASE.
- RELEASE:
  - Wait for Alu_Ack = 0.
  - If cmd_cntr == NUM_CMDS, go to DONE.
  - Otherwise Rom_Addr += 1 (wraps modulo 2**ADDR_W) and go to FETCH.
- DONE: Done = 1, Busy = 0, operands hold their last values.
- Timeout:
  - One counter, reset on every state entry, counts cycles spent in REQ, WAIT_ACK or RELEASE.
  - On reaching TIMEOUT: Err = 1, Alu_Req = 0, go to DONE. cmd_cntr keeps the count of completed commands only.
- Latency: minimum 4 cycles per command (FETCH, REQ, WAIT_ACK, RELEASE) when Ack arrives in the cycle after Req.
- Result_Valid and a cmd_cntr increment never occur without a sampled Ack rise in WAIT_ACK.

Decomposition:
- Shared package holds:
  - state enum: IDLE, FETCH, REQ, WAIT_ACK, RELEASE, DONE;
  - command field constants: CMD_MSB=2*N+1, OP1_MSB=2*N-1, OP2_MSB=N-1;
  - ALU opcode localparams.
- One sub-module, seq_timeout_ctr: loadable down-counter with clear and expire output, parameterised by TIMEOUT.

Test Plan:
- ROM holds 16 words, ALU acks 1 cycle after Req, Start pulsed -> Rom_Addr 0..15, cmd_cntr ends at 16, Done=1, Err=0, 16 Result_Valid pulses, total run 64 cycles + 1.
- Word 0 = 18'b01_00000011_00000101, Cin_In=1 -> Alu_Cmd=2'b01, Op1=8'h03, Op2=8'h05, Alu_Cin=1 stable while Req high; Result equals the driven Alu_Out.
- ALU holds Ack high 5 cycles per command -> Req stays low until Ack falls; no double count; cmd_cntr increments once per command.
- ALU never acks command 3, TIMEOUT=64 -> after 64 cycles in WAIT_ACK: Err=1, Req=0, Done=1, cmd_cntr=3.
- Rst asserted during WAIT_ACK of command 7 -> all outputs 0 asynchronously; next Start restarts at Rom_Addr=0, cmd_cntr=0.
- Start pulsed while Busy -> ignored; Start in DONE with Err=1 -> Err cleared and a new run begins.
